// File: rtl/intr_ctrl_if.sv
// CPU-side and memory-mapped signals of the interrupt controller, bundled
// so the CPU model / bus master and the controller share one connection.
interface intr_ctrl_if;
    logic        CSR_MSTATUS_MIE;
    logic        INSTR_BOUNDARY;
    logic        MRET_EXEC;
    logic        MM_WE;
    logic [1:0]  MM_ADDR;
    logic [31:0] MM_WD;
    logic [31:0] MM_RD;
    logic        INT_REQ;
    logic        INT_TAKEN;
    logic [3:0]  INT_CAUSE;

    // CPU / bus side: drives enables, boundary, mret and register writes.
    modport master (
        output CSR_MSTATUS_MIE, INSTR_BOUNDARY, MRET_EXEC,
        output MM_WE, MM_ADDR, MM_WD,
        input  MM_RD, INT_REQ, INT_TAKEN, INT_CAUSE
    );

    // Controller side.
    modport slave (
        input  CSR_MSTATUS_MIE, INSTR_BOUNDARY, MRET_EXEC,
        input  MM_WE, MM_ADDR, MM_WD,
        output MM_RD, INT_REQ, INT_TAKEN, INT_CAUSE
    );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller for the OTTER CSR unit: synchronizes and edge-detects
// external IRQ lines, latches them as pending, masks them, and sequences
// interrupt entry (INT_TAKEN pulse) and exit (MRET_EXEC).
//
// Handshake: INT_REQ acts as "valid" and INSTR_BOUNDARY as "ready". An
// interrupt is accepted on the rising CLK edge where both are high; the
// CAUSE is latched and the pending bit cleared on that same edge. INT_REQ
// stays low from acceptance until MRET_EXEC is seen in SERVICE.
module intr_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    intr_ctrl_if.slave         bus,
    output logic [1:0]         DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] sel_oh;
    logic [3:0]         sel;
    logic [3:0]         cause_q;
    logic               take;
    logic               unused_wd;

    assign irq_edge  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign active    = pend_q & mask_q;
    // Isolate the lowest set bit: lowest index has the highest priority.
    assign sel_oh    = active & (~active + 1'b1);
    assign take      = bus.INT_REQ & bus.INSTR_BOUNDARY;
    assign unused_wd = ^bus.MM_WD;

    assign bus.INT_REQ   = (state_q == IDLE) & (|active) & bus.CSR_MSTATUS_MIE;
    assign bus.INT_TAKEN = (state_q == TAKE);
    assign bus.INT_CAUSE = cause_q;
    assign DBG_STATE     = state_q;

    // Binary index of the highest-priority (lowest-numbered) active source.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) sel = 4'(i);
        end
    end

    // Multi-stage synchronizer per line plus one delay stage for edge detect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= IRQ_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pending update: take-clear and W1C first, then a new edge wins.
    always_comb begin
        pend_d = pend_q;
        if (take) pend_d = pend_d & ~sel_oh;
        if (bus.MM_WE && bus.MM_ADDR == 2'd1) pend_d = pend_d & ~bus.MM_WD[NUM_SRC-1:0];
        pend_d = pend_d | irq_edge;
    end

    // Pending, mask and cause registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q  <= '0;
            mask_q  <= '0;
            cause_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.MM_WE && bus.MM_ADDR == 2'd0) mask_q <= bus.MM_WD[NUM_SRC-1:0];
            // sel comes from the pre-write mask, so a same-cycle MASK write
            // cannot alter the cause being latched.
            if (take) cause_q <= sel;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, pulse once in TAKE, wait for mret in SERVICE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = TAKE;
            TAKE:    state_d = SERVICE;
            SERVICE: if (bus.MRET_EXEC) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-mapped read mux.
    always_comb begin
        bus.MM_RD = '0;
        case (bus.MM_ADDR)
            2'd0: bus.MM_RD = 32'(mask_q);
            2'd1: bus.MM_RD = 32'(pend_q);
            2'd2: bus.MM_RD = {28'b0, cause_q};
            2'd3: bus.MM_RD = {30'b0, state_q == SERVICE, |active};
            default: bus.MM_RD = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural model that tracks
// IRQ history, pending/mask sets and a busy/pulse service flag.
module tb_intr_ctrl;
    localparam int N = 8;
    localparam int S = 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] irq;
    logic [1:0]   dbg_state;

    intr_ctrl_if bus ();

    intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ_IN    (irq),
        .bus       (bus),
        .DBG_STATE (dbg_state)
    );

    // Clock.
    initial forever #5 CLK = ~CLK;

    // Reference model state.
    logic [N-1:0] m_mask, m_pend;
    int           m_cause;
    bit           m_busy, m_pulse;
    logic [N-1:0] hist [$];
    logic [3:0]   exp_q [$];

    int           n_vec = 0;
    int           n_bad = 0;
    int           n_pulses = 0;
    logic [3:0]   last_cause = '0;
    logic [1:0]   dbg_idle, dbg_svc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit exp_req();
        return !m_busy && ((m_pend & m_mask) != '0) && bus.CSR_MSTATUS_MIE;
    endfunction

    function automatic logic [31:0] exp_rd();
        case (bus.MM_ADDR)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_pend);
            2'd2:    return 32'(m_cause);
            default: return {30'b0, m_busy && !m_pulse, (m_pend & m_mask) != '0};
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        logic [N-1:0] edge_v, pend_n;
        int k, sz;
        bit take;
        if (RST) begin
            m_mask = '0; m_pend = '0; m_cause = 0; m_busy = 0; m_pulse = 0;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
            exp_q.delete();
            return;
        end
        sz     = hist.size();
        // hist[sz-1] is the sample from the previous edge; the synchronized
        // view lags S samples, the edge compares it with one sample older.
        edge_v = hist[sz-S] & ~hist[sz-S-1];
        take   = exp_req() && bus.INSTR_BOUNDARY;
        pend_n = m_pend;
        if (take) begin
            k = lowest(m_pend & m_mask);
            pend_n[k] = 1'b0;
            m_cause = k;
            exp_q.push_back(4'(k));
        end
        if (bus.MM_WE && bus.MM_ADDR == 2'd1) pend_n = pend_n & ~bus.MM_WD[N-1:0];
        pend_n = pend_n | edge_v;
        if (bus.MM_WE && bus.MM_ADDR == 2'd0) m_mask = bus.MM_WD[N-1:0];
        m_pend = pend_n;
        if (m_pulse) m_pulse = 0;
        else if (m_busy && bus.MRET_EXEC) m_busy = 0;
        else if (take) begin m_busy = 1; m_pulse = 1; end
        hist.push_back(irq);
        void'(hist.pop_front());
    endtask

    task automatic check_outputs();
        check_eq("int_req",   32'(bus.INT_REQ),   32'(exp_req()));
        check_eq("int_taken", 32'(bus.INT_TAKEN), 32'(m_pulse));
        check_eq("int_cause", 32'(bus.INT_CAUSE), 32'(m_cause));
        check_eq("mm_rd",     bus.MM_RD,          exp_rd());
    endtask

    // One clock: check outputs for current inputs, then take the edge.
    task automatic tick();
        #1;
        check_outputs();
        if (bus.INT_TAKEN === 1'b1) begin
            n_pulses++;
            last_cause = bus.INT_CAUSE;
            check_eq("take_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("sb_cause", 32'(bus.INT_CAUSE), 32'(exp_q.pop_front()));
        end
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
        bus.MM_WE = 1'b1; bus.MM_ADDR = a; bus.MM_WD = d;
        tick();
        bus.MM_WE = 1'b0;
    endtask

    task automatic pulse_mret();
        bus.MRET_EXEC = 1'b1;
        tick();
        bus.MRET_EXEC = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.MM_ADDR = a;
        #1;
        check_eq(tag, bus.MM_RD, exp);
    endtask

    initial begin
        int p0;
        RST = 1'b1; irq = '0;
        bus.CSR_MSTATUS_MIE = 1'b0; bus.INSTR_BOUNDARY = 1'b0; bus.MRET_EXEC = 1'b0;
        bus.MM_WE = 1'b0; bus.MM_ADDR = 2'd0; bus.MM_WD = '0;
        @(posedge CLK); model_step(); #1;
        @(posedge CLK); model_step(); #1;
        RST = 1'b0;
        dbg_idle = dbg_state;
        check_eq("rst_req", 32'(bus.INT_REQ), 32'd0);
        read_check("rst_pend", 2'd1, 32'd0);

        // Single source through the full entry/exit sequence.
        mm_write(2'd0, 32'h08);
        bus.CSR_MSTATUS_MIE = 1'b1; bus.INSTR_BOUNDARY = 1'b1;
        irq = 8'h08;
        repeat (3) tick();
        check_eq("t1_req", 32'(bus.INT_REQ), 32'd1);
        tick();
        check_eq("t1_taken", 32'(bus.INT_TAKEN), 32'd1);
        check_eq("t1_cause", 32'(bus.INT_CAUSE), 32'd3);
        read_check("t1_pend", 2'd1, 32'h00);
        tick();
        dbg_svc = dbg_state;
        read_check("t1_status_svc", 2'd3, 32'h2);
        pulse_mret();
        read_check("t1_status_idle", 2'd3, 32'h0);
        check_eq("dbg_distinct", 32'(dbg_idle != dbg_svc), 32'd1);

        // Two simultaneous sources: lowest index first.
        irq = '0;
        mm_write(2'd0, 32'hFF);
        repeat (3) tick();
        p0 = n_pulses;
        irq = 8'h24;
        repeat (6) tick();
        check_eq("t2_first_cause", 32'(last_cause), 32'd2);
        pulse_mret();
        repeat (6) tick();
        check_eq("t2_second_cause", 32'(last_cause), 32'd5);
        pulse_mret();
        repeat (4) tick();
        check_eq("t2_pulses", 32'(n_pulses - p0), 32'd2);

        // Masked pending source is held until unmasked.
        mm_write(2'd0, 32'h00);
        irq = '0;
        repeat (3) tick();
        irq = 8'h02;
        repeat (20) tick();
        check_eq("t3_req_masked", 32'(bus.INT_REQ), 32'd0);
        mm_write(2'd0, 32'h02);
        check_eq("t3_req_unmasked", 32'(bus.INT_REQ), 32'd1);
        tick();
        tick();

        // New edge during SERVICE latches but does not request until mret.
        mm_write(2'd0, 32'h03);
        irq = 8'h03;
        repeat (5) tick();
        read_check("t4_pend", 2'd1, 32'h01);
        check_eq("t4_req_svc", 32'(bus.INT_REQ), 32'd0);
        pulse_mret();
        check_eq("t4_req_idle", 32'(bus.INT_REQ), 32'd1);
        tick();
        tick();
        pulse_mret();

        // Edge coinciding with W1C keeps the bit; a lone W1C clears it.
        bus.CSR_MSTATUS_MIE = 1'b0;
        irq = 8'h13;
        tick();
        tick();
        mm_write(2'd1, 32'h10);
        bus.MM_ADDR = 2'd1; #1;
        check_eq("t5_set_beats_w1c", bus.MM_RD & 32'h10, 32'h10);
        mm_write(2'd1, 32'h10);
        bus.MM_ADDR = 2'd1; #1;
        check_eq("t5_w1c", bus.MM_RD & 32'h10, 32'h00);

        // Reset during SERVICE.
        bus.CSR_MSTATUS_MIE = 1'b1;
        mm_write(2'd0, 32'hFF);
        mm_write(2'd1, 32'hFF);
        irq = '0;
        repeat (3) tick();
        irq = 8'h07;
        repeat (6) tick();
        read_check("t6_pend_before", 2'd1, 32'h06);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        read_check("t6_pend", 2'd1, 32'h0);
        read_check("t6_mask", 2'd0, 32'h0);
        read_check("t6_cause", 2'd2, 32'h0);
        read_check("t6_status", 2'd3, 32'h0);
        check_eq("t6_req", 32'(bus.INT_REQ), 32'd0);
        check_eq("t6_taken", 32'(bus.INT_TAKEN), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            bus.CSR_MSTATUS_MIE = ($urandom_range(0, 9) != 0);
            bus.INSTR_BOUNDARY  = $urandom_range(0, 1) == 1;
            bus.MRET_EXEC       = ($urandom_range(0, 5) == 0);
            bus.MM_WE           = ($urandom_range(0, 7) == 0);
            bus.MM_ADDR         = 2'($urandom_range(0, 3));
            bus.MM_WD           = $urandom;
            RST                 = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0; bus.MM_WE = 1'b0; bus.MRET_EXEC = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
